// File: rtl/mdu_pkg.sv
// Shared types and opcode-decode helpers for the iterative multiply/divide unit.
// The optional MDU_EARLY_OUT_EN build shortcut is implemented in mdu_iter.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // MUL treats operands as unsigned: the low half of the product is sign-agnostic.
    function automatic logic is_signed_a(mdu_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(mdu_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(mdu_op_t op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Operation/result handshake bundle between the EX stage and mdu_iter.
interface mdu_iter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) ();

    // A transfer happens on a rising edge where valid && ready; the source holds its payload
    // stable while valid && !ready, and ready never depends combinationally on valid.
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    ALUResult;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult
    );

endinterface

// File: rtl/mdu_operand_prep.sv
// Combinational operand conditioning: magnitudes, sign flags and RISC-V special-case flags.
module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mdu_op_t               i_op,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    output logic [DATA_WIDTH-1:0] o_mag_a,
    output logic [DATA_WIDTH-1:0] o_mag_b,
    output logic                  o_neg_a,
    output logic                  o_neg_b,
    output logic                  o_div_zero,
    output logic                  o_div_ovf,
    output logic                  o_mul_zero
);

    localparam logic [DATA_WIDTH-1:0] W_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        o_neg_a    = is_signed_a(i_op) & i_src_a[DATA_WIDTH-1];
        o_neg_b    = is_signed_b(i_op) & i_src_b[DATA_WIDTH-1];
        o_mag_a    = o_neg_a ? -i_src_a : i_src_a;
        o_mag_b    = o_neg_b ? -i_src_b : i_src_b;
        o_div_zero = is_div(i_op) && (i_src_b == '0);
        o_div_ovf  = is_div(i_op) && is_signed_a(i_op) && (i_src_a == W_MOST_NEG) && (i_src_b == '1);
        o_mul_zero = !is_div(i_op) && ((i_src_a == '0) || (i_src_b == '0));
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit with IDLE/CALC/DONE control.
// Define MDU_EARLY_OUT_EN to let trivial/special cases skip the iteration loop.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3,
    parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    mdu_iter_if.slave  bus,
    output mdu_state_t o_dbg_state
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH);

    mdu_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    mdu_op_t              r_op;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_div_zero;
    logic                 r_div_ovf;
    logic                 r_mul_zero;
    logic                 r_early;
    logic [W-1:0]         r_opnd;
    logic [W-1:0]         r_src_a;
    logic [2*W-1:0]       r_prod;
    logic [W-1:0]         r_result;

    mdu_op_t      w_op;
    logic [W-1:0] w_mag_a;
    logic [W-1:0] w_mag_b;
    logic         w_neg_a;
    logic         w_neg_b;
    logic         w_div_zero;
    logic         w_div_ovf;
    logic         w_mul_zero;
    logic         w_early;

    assign w_op = mdu_op_t'(bus.Operation[2:0]);

    mdu_operand_prep #(.DATA_WIDTH(W)) u_prep (
        .i_op       (w_op),
        .i_src_a    (bus.SrcA),
        .i_src_b    (bus.SrcB),
        .o_mag_a    (w_mag_a),
        .o_mag_b    (w_mag_b),
        .o_neg_a    (w_neg_a),
        .o_neg_b    (w_neg_b),
        .o_div_zero (w_div_zero),
        .o_div_ovf  (w_div_ovf),
        .o_mul_zero (w_mul_zero)
    );

`ifdef MDU_EARLY_OUT_EN
    assign w_early = w_div_zero | w_div_ovf | w_mul_zero;
`else
    assign w_early = 1'b0;
`endif

    // r_prod is {high, low}: product accumulator for multiply, {remainder, quotient} for divide.
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_trial;
    logic           w_div_ge;
    logic [2*W-1:0] w_div_next;

    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*W-1:W]} + {1'b0, (r_prod[0] ? r_opnd : {W{1'b0}})};
        w_mul_next  = {w_mul_sum, r_prod[W-1:1]};
        w_div_trial = {r_prod[2*W-1:W], r_prod[W-1]} - {1'b0, r_opnd};
        w_div_ge    = !w_div_trial[W];
        w_div_next  = {(w_div_ge ? w_div_trial[W-1:0] : r_prod[2*W-2:W-1]), r_prod[W-2:0], w_div_ge};
    end

    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;
    logic [W-1:0]   w_result;
    logic           w_fin;

    always_comb begin
        w_prod_fix = r_neg_res ? -r_prod : r_prod;
        w_quo_fix  = r_neg_res ? -r_prod[W-1:0] : r_prod[W-1:0];
        w_rem_fix  = r_neg_rem ? -r_prod[2*W-1:W] : r_prod[2*W-1:W];
        case (r_op)
            OP_MUL:                        w_result = w_prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:               w_result = w_quo_fix;
            default:                       w_result = w_rem_fix;
        endcase
        // Architectural results for special cases win over whatever the loop produced.
        if (r_div_zero) begin
            w_result = is_rem(r_op) ? r_src_a : {W{1'b1}};
        end else if (r_div_ovf) begin
            w_result = is_rem(r_op) ? {W{1'b0}} : r_src_a;
        end else if (r_mul_zero) begin
            w_result = '0;
        end
        w_fin = r_early || (r_cnt == LAST_CNT);
    end

    // CALC steps on counts 0..W-1; the count-W cycle only sign-corrects and registers the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_mul_zero <= 1'b0;
            r_early    <= 1'b0;
            r_opnd     <= '0;
            r_src_a    <= '0;
            r_prod     <= '0;
            r_result   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state    <= CALC;
                        r_cnt      <= '0;
                        r_op       <= w_op;
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_div_zero <= w_div_zero;
                        r_div_ovf  <= w_div_ovf;
                        r_mul_zero <= w_mul_zero;
                        r_early    <= w_early;
                        r_src_a    <= bus.SrcA;
                        r_opnd     <= is_div(w_op) ? w_mag_b : w_mag_a;
                        r_prod     <= {{W{1'b0}}, (is_div(w_op) ? w_mag_a : w_mag_b)};
                    end
                end
                CALC: begin
                    if (w_fin) begin
                        r_result <= w_result;
                        r_state  <= DONE;
                    end else begin
                        r_prod <= is_div(r_op) ? w_div_next : w_mul_next;
                        r_cnt  <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.ALUResult = r_result;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the RV32M extension; parametrised in data width.
- Sits beside the combinational ALU in EX, which keeps AND/OR/ADD/SUB/XOR/compare/LUI.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU over multiple cycles.
- Uses a valid/ready handshake on both input and output, so the pipeline stalls EX while busy.

Parameters:
- DATA_WIDTH, 32: operand/result width; must be even and >= 8.
- OPCODE_LENGTH, 3: width of Operation; carries funct3 directly.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any operation in flight.
- in_valid  in  1  operands and Operation valid.
- in_ready  out  1  unit can accept an operation.
- Operation  in  OPCODE_LENGTH  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  DATA_WIDTH  rs1 (multiplicand/dividend).
- SrcB  in  DATA_WIDTH  rs2 (multiplier/divisor).
- out_valid  out  1  ALUResult valid.
- out_ready  in  1  consumer takes result.
- ALUResult  out  DATA_WIDTH  registered result.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, counter=0, all datapath registers 0.
  - in_ready=1, out_valid=0, ALUResult=0.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE), combinational from state only.
  - out_valid = (state==DONE).
- IDLE -> CALC on in_valid && in_ready at edge T:
  - Latch op and sign flags.
  - Convert operands to magnitudes per op signedness: MULH both signed; MULHSU A signed, B unsigned; DIV/REM both signed.
- CALC: one radix-2 step per cycle; counter runs 0..DATA_WIDTH-1.
  - Multiply: shift-add into a 2*DATA_WIDTH product register.
  - Divide: restoring shift-subtract, giving quotient and remainder.
- Last CALC cycle registers the sign-corrected result into ALUResult and moves to DONE.
  - Multiply: negate product if signs differ.
  - Quotient: negate if signs differ.
  - Remainder: takes the dividend's sign.
- Latency: out_valid high from edge T+DATA_WIDTH+1 (33 cycles at default).
- Result selection:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE -> IDLE on out_ready.
  - ALUResult holds stable while out_valid && !out_ready.
  - No new operation is accepted in the same cycle as the DONE->IDLE transition; the next accept is earliest the following edge.
- Special cases, RISC-V-defined results:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> SrcA.
  - Signed overflow (SrcA = -2^(W-1), SrcB = -1): DIV -> SrcA; REM -> 0.
  - Without the optional feature, special cases still take the full latency.
- flush:
  - From any state, next edge goes to IDLE with out_valid=0; the result is discarded.
  - flush overrides a simultaneous accept: in_valid is ignored that cycle.
- Asynchronous reset mid-CALC: immediate return to reset values; no partial result is ever presented.
- Operation values outside the 3-bit range cannot occur (OPCODE_LENGTH=3).
  - If OPCODE_LENGTH > 3, only the low 3 bits are decoded.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Divide by zero, signed overflow, and any multiply with either operand 0 skip CALC.
  - Result is registered at edge T+1; out_valid is high from T+1.
- Undefined: every operation takes DATA_WIDTH+1 cycles.
- Results are bit-identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_t enum (the 8 funct3 codes).
  - mdu_state_t enum {IDLE, CALC, DONE}.
  - Helper functions is_signed_a(op), is_signed_b(op), is_div(op).
- One sub-module: mdu_operand_prep. It is combinational: it takes the operands and op and produces magnitudes, sign flags and special-case flags. Reused by a future radix-4 variant.
- The iteration datapath and FSM stay in mdu_iter.

Test Plan:
- MUL, A=7, B=-3 -> ALUResult=0xFFFFFFEB; out_valid exactly 33 cycles after accept; in_ready low throughout.
- MULH, A=0x80000000, B=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU, A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV, A=-7, B=2 -> quotient 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. DIVU, A=100, B=7 -> 14; REMU -> 2.
- DIV, A=5, B=0 -> 0xFFFFFFFF; REM -> 5. DIV, A=0x80000000, B=-1 -> 0x80000000; REM -> 0. Latency is 33 without MDU_EARLY_OUT_EN and 1 with it.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> ALUResult stable, in_ready=0. Release -> IDLE next edge; a new op is accepted the edge after.
- Assert flush at CALC cycle 12 -> IDLE next edge, out_valid never rises. Drop reset mid-CALC -> outputs return to reset values immediately. A subsequent MUL 3x4 -> 12.
